// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared state encoding and helpers for the key debouncer
//   db_state_e  per-key debounce FSM state (2-bit encoding)
//   is_pressed  1 when a state represents an accepted pressed level
`timescale 1ns/1ps
package key_debounce_pkg;
  typedef enum logic [1:0] {
    DB_STABLE_UP   = 2'd0,
    DB_PEND_DOWN   = 2'd1,
    DB_STABLE_DOWN = 2'd2,
    DB_PEND_UP     = 2'd3
  } db_state_e;
  function automatic logic is_pressed(input db_state_e s);
    return s inside {DB_STABLE_DOWN, DB_PEND_UP};
  endfunction
endpackage

// File: rtl/key_debounce_cell.sv
// key_debounce_cell: synchroniser, stability counter and debounce FSM for one key
//   clk, rst_n  clock, asynchronous active-low reset
//   key_i       raw key, already normalised so 1 = pressed
//   level_o     debounced level, 1 = pressed
//   press_o     one-cycle strobe on an accepted press
//   release_o   one-cycle strobe on an accepted release
`timescale 1ns/1ps
module key_debounce_cell
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  logic             s1_q, s2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d, release_q, release_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= DB_STABLE_UP;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= key_i;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end
  // cnt counts consecutive samples that disagree with the accepted level;
  // it is cleared on every stable hold, rejection and acceptance, so it never wraps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      DB_STABLE_UP: if (s2_q) begin
        state_d = DB_PEND_DOWN;
        cnt_d   = CNT_ONE;
      end
      DB_PEND_DOWN: if (!s2_q) state_d = DB_STABLE_UP;
        else if (cnt_q == CNT_LAST) begin
          state_d = DB_STABLE_DOWN;
          press_d = 1'b1;
        end else cnt_d = cnt_q + CNT_ONE;
      DB_STABLE_DOWN: if (!s2_q) begin
        state_d = DB_PEND_UP;
        cnt_d   = CNT_ONE;
      end
      DB_PEND_UP: if (s2_q) state_d = DB_STABLE_DOWN;
        else if (cnt_q == CNT_LAST) begin
          state_d   = DB_STABLE_UP;
          release_d = 1'b1;
        end else cnt_d = cnt_q + CNT_ONE;
    endcase
  end
  assign level_o   = is_pressed(state_q);
  assign press_o   = press_q;
  assign release_o = release_q;
endmodule

// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces N_KEYS raw key inputs
//   clk, rst_n   clock, asynchronous active-low reset
//   key_in       raw asynchronous key/button pins
//   key_level    debounced level per key, 1 = pressed regardless of ACTIVE_HIGH
//   key_press    one-cycle strobe when key_level rises
//   key_release  one-cycle strobe when key_level falls
`timescale 1ns/1ps
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int ACTIVE_HIGH     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);
  localparam logic [N_KEYS-1:0] INV = (ACTIVE_HIGH != 0) ? '0 : '1;
  logic [N_KEYS-1:0] norm;
  assign norm = key_in ^ INV;
  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_i    (norm[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i])
    );
  end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: randomized scoreboard bench for key_debounce (active-high and active-low instances)
`timescale 1ns/1ps
module tb_key_debounce;
  localparam int N = 2;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] key_in = '0;
  logic [N-1:0] key_in_n;
  logic [N-1:0] lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b;
  int checks = 0;
  int failures = 0;
  int strobes = 0;
  always #1 clk = ~clk;
  assign key_in_n = ~key_in;
  key_debounce #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_HIGH(1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_level(lvl_a), .key_press(prs_a), .key_release(rel_a));
  key_debounce #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_HIGH(0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .key_in(key_in_n),
    .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b));
  // Reference: each key keeps its accepted level and the length of the current run
  // of samples that disagree with it; a run reaching D flips the level and strobes.
  // Pin values reach the decision two edges after they are sampled.
  logic [3*N-1:0] exp_q[$];
  logic [N-1:0] m_lvl = '0;
  logic [N-1:0] m_d1 = '0, m_d2 = '0;
  int m_run[N];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lvl = '0;
      m_d1 = '0;
      m_d2 = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      exp_q.delete();
    end else begin
      logic [N-1:0] p, r, s;
      p = '0;
      r = '0;
      s = m_d2;
      m_d2 = m_d1;
      m_d1 = key_in;
      for (int i = 0; i < N; i++) begin
        if (s[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_lvl[i] = s[i];
            m_run[i] = 0;
            if (s[i]) p[i] = 1'b1;
            else r[i] = 1'b1;
          end
        end else m_run[i] = 0;
      end
      exp_q.push_back({m_lvl, p, r});
    end
  end
  task automatic check(input string name, input logic [3*N-1:0] got, input logic [3*N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got lvl/press/rel=%b required=%b", name, $time, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      check("reset_hi", {lvl_a, prs_a, rel_a}, '0);
      check("reset_lo", {lvl_b, prs_b, rel_b}, '0);
    end else if (exp_q.size() != 0) begin
      logic [3*N-1:0] e;
      e = exp_q.pop_front();
      if (e[2*N-1:0] != '0) strobes++;
      check("active_high", {lvl_a, prs_a, rel_a}, e);
      check("active_low", {lvl_b, prs_b, rel_b}, e);
    end
  end
  task automatic hold(input logic [N-1:0] v, input int n);
    key_in = v;
    repeat (n) begin
      @(posedge clk);
      #0.5;
    end
  endtask
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #0.5;
    end
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    hold(2'b00, 3);
    rst_n = 1'b1;
    hold(2'b00, 5);
    hold(2'b01, 10);
    hold(2'b00, 10);
    for (int i = 0; i < 3; i++) begin
      hold(2'b00, 2);
      hold(2'b01, 2);
    end
    hold(2'b01, 10);
    hold(2'b00, 10);
    hold(2'b10, D - 1);
    hold(2'b00, 8);
    hold(2'b10, D);
    hold(2'b00, 10);
    hold(2'b11, 10);
    hold(2'b00, 10);
    hold(2'b01, 4);
    do_reset(2);
    hold(2'b01, 10);
    do_reset(2);
    hold(2'b01, 10);
    hold(2'b00, 10);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
      hold(2'($urandom_range(0, 3)), $urandom_range(1, 7));
    end
    hold(2'b00, 12);
    checks++;
    if (strobes < 10) begin
      failures++;
      $display("FAIL strobe_activity got=%0d required>=10", strobes);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
